// File: rtl/voice_allocator.sv
// Purpose: assigns note events to NUM_VOICES voices (retrigger > free > oldest released > steal oldest held).
// Latency: one cycle; an event strobed in cycle N updates gate/pitch/trig/steal/count visible in cycle N+1.
// Backpressure: none; every strobe is accepted, one event per cycle, each seeing the previous event's result.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int MIDI_BYTES = 24
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [MIDI_BYTES-1:0]         midi_event_in,
  input  logic                          midi_valid_in,
  input  logic [NUM_VOICES-1:0]         voice_active_in,
  output logic [NUM_VOICES-1:0]         voice_gate_out,
  output logic [8*NUM_VOICES-1:0]       voice_pitch_out,
  output logic [NUM_VOICES-1:0]         voice_trig_out,
  output logic [$clog2(NUM_VOICES):0]   voices_held_out,
  output logic                          steal_out
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam int CW = RW + 1;

  typedef logic [RW-1:0] rank_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_evt_t;

  midi_evt_t evt;

  // Registered voice state; FREE/RELEASED/HELD are derived from gate and active.
  logic [NUM_VOICES-1:0]       gate_q, gate_d;
  logic [NUM_VOICES-1:0][7:0]  pitch_q, pitch_d;
  logic [NUM_VOICES-1:0]       trig_q, trig_d;
  logic [CW-1:0]               held_q, held_d;
  logic                        steal_q, steal_d;
  rank_t                       rank_q [NUM_VOICES];
  rank_t                       rank_d [NUM_VOICES];

  logic is_note_on, is_note_off, is_all_off;

  // Candidate search results
  logic  hit_found, free_found, rel_found, held_found;
  rank_t hit_idx, free_idx, rel_idx, held_idx;
  rank_t rel_rank, held_rank;
  rank_t sel_idx;
  logic  sel_steal;

  assign evt = midi_event_in[MIDI_BYTES-1 -: 24];

  // Channel-0 event decode; running velocity 0 on a note-on is a note-off.
  always_comb begin
    is_note_on  = midi_valid_in && (evt.status == 8'h90) && (evt.data2 != 8'h00);
    is_note_off = midi_valid_in && ((evt.status == 8'h80) ||
                                    ((evt.status == 8'h90) && (evt.data2 == 8'h00)));
    is_all_off  = midi_valid_in && (evt.status == 8'hB0) && (evt.data1 == 8'h7B);
  end

  // Scan voices for a same-pitch held voice, lowest free, oldest released and oldest held.
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    rel_found  = 1'b0;
    held_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    rel_idx    = '0;
    held_idx   = '0;
    rel_rank   = '0;
    held_rank  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (gate_q[v]) begin
        if (!hit_found && (pitch_q[v] == evt.data1)) begin
          hit_found = 1'b1;
          hit_idx   = RW'(v);
        end
        if (!held_found || (rank_q[v] > held_rank)) begin
          held_found = 1'b1;
          held_idx   = RW'(v);
          held_rank  = rank_q[v];
        end
      end else if (voice_active_in[v]) begin
        if (!rel_found || (rank_q[v] > rel_rank)) begin
          rel_found = 1'b1;
          rel_idx   = RW'(v);
          rel_rank  = rank_q[v];
        end
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = RW'(v);
      end
    end
  end

  // Priority pick; every voice is in exactly one class, so some voice is always chosen.
  always_comb begin
    sel_idx   = held_idx;
    sel_steal = 1'b1;
    if (hit_found) begin
      sel_idx   = hit_idx;
      sel_steal = 1'b0;
    end else if (free_found) begin
      sel_idx   = free_idx;
      sel_steal = 1'b0;
    end else if (rel_found) begin
      sel_idx   = rel_idx;
      sel_steal = 1'b0;
    end
  end

  // Next-state: apply the decoded event to gates, pitches, ranks and pulses.
  always_comb begin
    gate_d  = gate_q;
    pitch_d = pitch_q;
    trig_d  = '0;
    steal_d = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank_d[v] = rank_q[v];
    end
    if (is_note_on) begin
      // Promote the chosen voice to newest; everything newer than it ages by one,
      // which keeps the ranks a permutation.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rank_q[v] < rank_q[sel_idx]) begin
          rank_d[v] = rank_q[v] + RW'(1);
        end
        if (RW'(v) == sel_idx) begin
          rank_d[v]  = '0;
          gate_d[v]  = 1'b1;
          pitch_d[v] = evt.data1;
          trig_d[v]  = 1'b1;
        end
      end
      steal_d = sel_steal;
    end else if (is_note_off) begin
      // Pitch and rank are kept so the release tail plays at the right note.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (gate_q[v] && (pitch_q[v] == evt.data1)) begin
          gate_d[v] = 1'b0;
        end
      end
    end else if (is_all_off) begin
      gate_d = '0;
    end
  end

  // Held-voice count tracks the next gate vector so it lands in the same cycle.
  always_comb begin
    held_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      held_d = held_d + CW'(gate_d[v]);
    end
  end

  // State registers; reset makes voice v rank v so voice 0 starts as newest.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gate_q  <= '0;
      pitch_q <= '0;
      trig_q  <= '0;
      held_q  <= '0;
      steal_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= RW'(v);
      end
    end else begin
      gate_q  <= gate_d;
      pitch_q <= pitch_d;
      trig_q  <= trig_d;
      held_q  <= held_d;
      steal_q <= steal_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= rank_d[v];
      end
    end
  end

  assign voice_gate_out  = gate_q;
  assign voice_pitch_out = pitch_q;
  assign voice_trig_out  = trig_q;
  assign voices_held_out = held_q;
  assign steal_out       = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Purpose: directed vector bench for voice_allocator (4 voices).
// Latency: inputs driven on the falling edge, outputs checked 1 time unit after the next rising edge.
// Backpressure: none; one row per clock.
module tb_voice_allocator;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [23:0] midi_event_in = '0;
  logic        midi_valid_in = 1'b0;
  logic [3:0]  voice_active_in = '0;
  logic [3:0]  voice_gate_out;
  logic [31:0] voice_pitch_out;
  logic [3:0]  voice_trig_out;
  logic [2:0]  voices_held_out;
  logic        steal_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  voice_allocator #(.NUM_VOICES(4), .MIDI_BYTES(24)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .midi_event_in   (midi_event_in),
    .midi_valid_in   (midi_valid_in),
    .voice_active_in (voice_active_in),
    .voice_gate_out  (voice_gate_out),
    .voice_pitch_out (voice_pitch_out),
    .voice_trig_out  (voice_trig_out),
    .voices_held_out (voices_held_out),
    .steal_out       (steal_out)
  );

  typedef struct {
    bit          rst;
    bit          vld;
    logic [23:0] evt;
    logic [3:0]  act;
    logic [3:0]  gate;
    logic [31:0] pitch;
    logic [3:0]  trig;
    logic [2:0]  held;
    bit          steal;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit vld, logic [23:0] evt, logic [3:0] act,
                              logic [3:0] gate, logic [31:0] pitch, logic [3:0] trig,
                              logic [2:0] held, bit steal);
    vec_t r;
    r.rst = rst; r.vld = vld; r.evt = evt; r.act = act;
    r.gate = gate; r.pitch = pitch; r.trig = trig; r.held = held; r.steal = steal;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one row on the falling edge, check after the following rising edge.
  task automatic run_vec(input vec_t r, input int idx);
    @(negedge clk_in);
    rst_in          = r.rst;
    midi_valid_in   = r.vld;
    midi_event_in   = r.evt;
    voice_active_in = r.act;
    @(posedge clk_in);
    #1;
    chk("gate",  idx, 32'(voice_gate_out),  32'(r.gate));
    chk("pitch", idx, voice_pitch_out,      r.pitch);
    chk("trig",  idx, 32'(voice_trig_out),  32'(r.trig));
    chk("held",  idx, 32'(voices_held_out), 32'(r.held));
    chk("steal", idx, 32'(steal_out),       32'(r.steal));
  endtask

  localparam logic [23:0] IDLE = 24'h000000;

  initial begin
    // rst vld event      act    gate   pitch          trig   held steal
    // Three note-ons from reset land on voices 0,1,2.
    vecs.push_back(mk(1, 0, IDLE,      4'h0, 4'h0, 32'h00000000, 4'h0, 3'd0, 0)); // 0
    vecs.push_back(mk(0, 1, 24'h903C40, 4'h0, 4'h1, 32'h0000003C, 4'h1, 3'd1, 0));
    vecs.push_back(mk(0, 1, 24'h904040, 4'h0, 4'h3, 32'h0000403C, 4'h2, 3'd2, 0));
    vecs.push_back(mk(0, 1, 24'h904340, 4'h0, 4'h7, 32'h0043403C, 4'h4, 3'd3, 0));
    vecs.push_back(mk(0, 0, IDLE,      4'h0, 4'h7, 32'h0043403C, 4'h0, 3'd3, 0));
    // Fill four voices, fifth note steals voice 0 (oldest).
    vecs.push_back(mk(1, 0, IDLE,      4'h0, 4'h0, 32'h00000000, 4'h0, 3'd0, 0)); // 5
    vecs.push_back(mk(0, 1, 24'h903C40, 4'h0, 4'h1, 32'h0000003C, 4'h1, 3'd1, 0));
    vecs.push_back(mk(0, 1, 24'h903E40, 4'h0, 4'h3, 32'h00003E3C, 4'h2, 3'd2, 0));
    vecs.push_back(mk(0, 1, 24'h904040, 4'h0, 4'h7, 32'h00403E3C, 4'h4, 3'd3, 0));
    vecs.push_back(mk(0, 1, 24'h904140, 4'h0, 4'hF, 32'h41403E3C, 4'h8, 3'd4, 0));
    vecs.push_back(mk(0, 1, 24'h904340, 4'h0, 4'hF, 32'h41403E43, 4'h1, 3'd4, 1)); // 10
    vecs.push_back(mk(0, 0, IDLE,      4'h0, 4'hF, 32'h41403E43, 4'h0, 3'd4, 0));
    // Released voice 1 reused, then the same with voice 1 free.
    vecs.push_back(mk(0, 1, 24'h803E40, 4'h2, 4'hD, 32'h41403E43, 4'h0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 24'h904640, 4'h2, 4'hF, 32'h41404643, 4'h2, 3'd4, 0));
    vecs.push_back(mk(0, 1, 24'h804600, 4'h0, 4'hD, 32'h41404643, 4'h0, 3'd3, 0));
    vecs.push_back(mk(0, 1, 24'h904640, 4'h0, 4'hF, 32'h41404643, 4'h2, 3'd4, 0)); // 15
    // Repeated note-on retriggers the same voice.
    vecs.push_back(mk(1, 0, IDLE,      4'h0, 4'h0, 32'h00000000, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 24'h903C40, 4'h0, 4'h1, 32'h0000003C, 4'h1, 3'd1, 0));
    vecs.push_back(mk(0, 1, 24'h903C50, 4'h0, 4'h1, 32'h0000003C, 4'h1, 3'd1, 0));
    vecs.push_back(mk(0, 0, IDLE,      4'h0, 4'h1, 32'h0000003C, 4'h0, 3'd1, 0));
    // Velocity-0 note-off, then ignored channel-1 note and pitch bend.
    vecs.push_back(mk(0, 1, 24'h903C00, 4'h1, 4'h0, 32'h0000003C, 4'h0, 3'd0, 0)); // 20
    vecs.push_back(mk(0, 1, 24'h913C40, 4'h1, 4'h0, 32'h0000003C, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 24'hE00040, 4'h1, 4'h0, 32'h0000003C, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 24'h804500, 4'h0, 4'h0, 32'h0000003C, 4'h0, 3'd0, 0));
    // All-notes-off keeps pitches and ranks; then released/free priority checks.
    vecs.push_back(mk(1, 0, IDLE,      4'h0, 4'h0, 32'h00000000, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 24'h903C40, 4'h0, 4'h1, 32'h0000003C, 4'h1, 3'd1, 0)); // 25
    vecs.push_back(mk(0, 1, 24'h903E40, 4'h0, 4'h3, 32'h00003E3C, 4'h2, 3'd2, 0));
    vecs.push_back(mk(0, 1, 24'h904040, 4'h0, 4'h7, 32'h00403E3C, 4'h4, 3'd3, 0));
    vecs.push_back(mk(0, 1, 24'h904140, 4'h0, 4'hF, 32'h41403E3C, 4'h8, 3'd4, 0));
    vecs.push_back(mk(0, 1, 24'hB07B00, 4'hF, 4'h0, 32'h41403E3C, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 1, 24'h904340, 4'hF, 4'h1, 32'h41403E43, 4'h1, 3'd1, 0)); // 30
    vecs.push_back(mk(0, 1, 24'h904640, 4'hE, 4'h3, 32'h41404643, 4'h2, 3'd2, 0));
    vecs.push_back(mk(0, 1, 24'h805000, 4'hE, 4'h3, 32'h41404643, 4'h0, 3'd2, 0));
    vecs.push_back(mk(0, 1, 24'h904840, 4'hA, 4'h7, 32'h41484643, 4'h4, 3'd3, 0));
    vecs.push_back(mk(0, 1, 24'h904A40, 4'h8, 4'hF, 32'h4A484643, 4'h8, 3'd4, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Asynchronous reset mid-stream: outputs clear before any clock edge.
    @(negedge clk_in);
    midi_valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("async_gate",  100, 32'(voice_gate_out),  32'h0);
    chk("async_pitch", 100, voice_pitch_out,      32'h0);
    chk("async_trig",  100, 32'(voice_trig_out),  32'h0);
    chk("async_held",  100, 32'(voices_held_out), 32'h0);
    chk("async_steal", 100, 32'(steal_out),       32'h0);

    // Ranks back to 0..3: with every voice released, voice 3 then voice 2 are chosen.
    run_vec(mk(0, 1, 24'h903C40, 4'hF, 4'h8, 32'h3C000000, 4'h8, 3'd1, 0), 101);
    run_vec(mk(0, 1, 24'h903E40, 4'hF, 4'hC, 32'h3C3E0000, 4'h4, 3'd2, 0), 102);
    run_vec(mk(0, 0, IDLE,      4'hF, 4'hC, 32'h3C3E0000, 4'h0, 3'd2, 0), 103);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
